pmem_fetch_arbiter: RTL
=======================

# pmem_fetch_arbiter

Read-only arbiter between the per-core instruction fetchers and the external program memory. It multiplexes NUM_CONSUMERS fetch requesters onto NUM_CHANNELS asynchronous program-memory read channels, using round-robin grant. Each grant is held through the full request/response handshake on both sides. It replaces the fixed two-port program memory hookup and makes the core count independent of the memory port count.

## Interface
- ADDR_BITS, 8: program memory address width
- DATA_BITS, 16: instruction width
- NUM_CONSUMERS, 2: number of fetchers (one per core)
- NUM_CHANNELS, 1: number of program memory read channels; must be ≤ NUM_CONSUMERS

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- consumer_read_valid  in  [NUM_CONSUMERS]  fetch request per consumer
- consumer_read_address  in  [ADDR_BITS] x NUM_CONSUMERS  fetch address, sampled at grant
- consumer_read_ready  out  [NUM_CONSUMERS]  response valid; held until consumer drops valid
- consumer_read_data  out  [DATA_BITS] x NUM_CONSUMERS  instruction, stable while ready high
- mem_read_valid  out  [NUM_CHANNELS]  request to program memory
- mem_read_address  out  [ADDR_BITS] x NUM_CHANNELS  request address, stable while valid high
- mem_read_ready  in  [NUM_CHANNELS]  memory response strobe
- mem_read_data  in  [DATA_BITS] x NUM_CHANNELS  instruction, sampled when ready high

## Operation
- Per-channel FSM with states IDLE, WAITING, RELAYING. Shared state: claimed[NUM_CONSUMERS], rr_ptr (clog2(NUM_CONSUMERS) bits).
- IDLE: scan consumers rr_ptr, rr_ptr+1, … (mod NUM_CONSUMERS). Pick the first c with valid=1 and claimed[c]=0.
  - On a pick: set claimed[c], latch c and its address, assert mem_read_valid, go to WAITING.
  - Same-edge contention: channels resolve in index order. Channel i never picks a consumer picked by channel j<i on the same edge.
- WAITING: on the edge where mem_read_ready=1, capture mem_read_data into the consumer's data register, then:
  - drop mem_read_valid;
  - if the consumer's valid is still 1: assert consumer_read_ready and go to RELAYING;
  - if the consumer's valid is 0 (abandoned fetch): discard the data, clear claimed, and go to IDLE.
- RELAYING: hold ready and data until the consumer's valid is sampled 0. Then drop ready, clear claimed, and go to IDLE.
- rr_ptr: after any edge with grants, rr_ptr = (highest-index channel's granted consumer + 1) mod NUM_CONSUMERS. It is unchanged on edges with no grants.
- Address changes from a consumer while it is claimed are ignored; the latched address is used.
- consumer_read_data for unclaimed consumers holds its last value.

## Timing
- Reset (reset=0) forces, asynchronously:
  - all mem_read_valid, consumer_read_ready, claimed = 0;
  - all address and data registers = 0;
  - rr_ptr = 0;
  - all FSMs = IDLE.
- Reset mid-transaction aborts the transaction. A late mem_read_ready is ignored after reset release.
- All outputs are registered; there is no combinational path from input to output.
- Grant: consumer valid sampled at edge N → mem_read_valid=1 after edge N.
- Response: mem_read_ready=1 sampled at edge M → mem_read_valid=0 and consumer_read_ready=1 after edge M. Minimum request-to-ready is 2 edges when memory answers in the grant cycle.
- Release: consumer valid sampled 0 at edge R → ready=0 and channel IDLE after R. The earliest new grant on that channel is at edge R+1.
- A consumer must not reassert valid in the same cycle it observes ready drop; the next request is sampled no earlier than R+1.
- Throughput per channel: at most one fetch per 3 cycles.
- With NUM_CONSUMERS > NUM_CHANNELS under continuous load, every requester is granted within NUM_CONSUMERS grants.

## Test plan
- Reset: drive reset=0 with both consumers valid → all outputs 0. Release reset → consumer 0 is granted first (mem_read_valid[0]=1 after the first edge).
- Single fetch, NUM_CHANNELS=1: consumer 1 requests address 0x2A, memory returns 0xBEEF in the grant cycle → consumer_read_ready[1]=1 with data 0xBEEF two edges after the request. Ready falls one edge after valid drops.
- Round-robin, 2 consumers, 1 channel, both held valid, memory zero-latency → grants alternate 0,1,0,1. Each consumer receives its own address's data.
- Two channels, 2 consumers requesting on the same edge → channel 0 serves consumer 0 and channel 1 serves consumer 1 in parallel. No consumer is ever claimed twice.
- Abandoned fetch: consumer drops valid while its channel is WAITING, then memory responds → consumer_read_ready stays 0, the channel returns to IDLE, and the next requester is granted.
- Reset mid-WAITING: assert reset while mem_read_valid=1 → mem_read_valid drops immediately. A mem_read_ready pulse after release produces no consumer_read_ready.

Source files
------------

// File: rtl/pmem_fetch_arbiter_if.sv
// Read request/response bundle for NUM_PORTS lanes; the master issues valid/address,
// the slave answers with ready/data.
interface pmem_fetch_arbiter_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned NUM_PORTS = 1
);
    logic [NUM_PORTS-1:0]                read_valid;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] read_address;
    logic [NUM_PORTS-1:0]                read_ready;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] read_data;

    modport master (
        output read_valid,
        output read_address,
        input  read_ready,
        input  read_data
    );

    modport slave (
        input  read_valid,
        input  read_address,
        output read_ready,
        output read_data
    );
endinterface

// File: rtl/pmem_fetch_arbiter.sv
// Round-robin arbiter from NUM_CONSUMERS instruction fetchers onto NUM_CHANNELS
// program-memory read channels; each grant is held through both handshakes.
module pmem_fetch_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 2,
    parameter int unsigned NUM_CHANNELS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pmem_fetch_arbiter_if.slave  consumer,
    pmem_fetch_arbiter_if.master mem
);
    localparam int unsigned PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef logic [PTR_BITS-1:0] ptr_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_RELAYING
    } state_t;

    if (NUM_CHANNELS == 0 || NUM_CHANNELS > NUM_CONSUMERS) begin : g_bad_params
        $error("pmem_fetch_arbiter: NUM_CHANNELS must be in 1..NUM_CONSUMERS");
    end

    state_t               state_q   [NUM_CHANNELS];
    state_t               state_d   [NUM_CHANNELS];
    ptr_t                 owner_q   [NUM_CHANNELS];
    ptr_t                 owner_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_q    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_d    [NUM_CHANNELS];
    logic [DATA_BITS-1:0] data_q    [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] data_d    [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] claimed_q;
    logic [NUM_CONSUMERS-1:0] claimed_d;
    ptr_t                 rr_q;
    ptr_t                 rr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= S_IDLE;
                owner_q[ch] <= '0;
                addr_q[ch]  <= '0;
            end
            for (int unsigned c = 0; c < NUM_CONSUMERS; c++) begin
                data_q[c] <= '0;
            end
            claimed_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            claimed_q <= claimed_d;
            rr_q      <= rr_d;
        end
    end

    // Channels are evaluated in index order; 'taken' carries this edge's picks forward
    // so a higher-index channel never grabs a consumer already picked below it.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        ptr_t                     pick;
        ptr_t                     cand;
        int unsigned              idx;

        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        data_d    = data_q;
        claimed_d = claimed_q;
        rr_d      = rr_q;
        taken     = claimed_q;

        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            pick  = '0;
            case (state_q[ch])
                S_IDLE: begin
                    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                        idx = k + 32'(rr_q);
                        if (idx >= NUM_CONSUMERS) begin
                            idx = idx - NUM_CONSUMERS;
                        end
                        cand = ptr_t'(idx);
                        if (!found && consumer.read_valid[cand] && !taken[cand]) begin
                            found = 1'b1;
                            pick  = cand;
                        end
                    end
                    if (found) begin
                        taken[pick]     = 1'b1;
                        claimed_d[pick] = 1'b1;
                        owner_d[ch]     = pick;
                        addr_d[ch]      = consumer.read_address[pick];
                        state_d[ch]     = S_WAITING;
                        rr_d            = (pick == ptr_t'(NUM_CONSUMERS - 1)) ? '0 : pick + 1'b1;
                    end
                end
                S_WAITING: begin
                    if (mem.read_ready[ch]) begin
                        if (consumer.read_valid[owner_q[ch]]) begin
                            data_d[owner_q[ch]] = mem.read_data[ch];
                            state_d[ch]         = S_RELAYING;
                        end else begin
                            claimed_d[owner_q[ch]] = 1'b0;
                            state_d[ch]            = S_IDLE;
                        end
                    end
                end
                S_RELAYING: begin
                    if (!consumer.read_valid[owner_q[ch]]) begin
                        claimed_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = S_IDLE;
                    end
                end
                default: begin
                    state_d[ch] = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        mem.read_valid        = '0;
        mem.read_address      = '0;
        consumer.read_ready   = '0;
        consumer.read_data    = '0;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem.read_valid[ch]   = (state_q[ch] == S_WAITING);
            mem.read_address[ch] = addr_q[ch];
            if (state_q[ch] == S_RELAYING) begin
                consumer.read_ready[owner_q[ch]] = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NUM_CONSUMERS; c++) begin
            consumer.read_data[c] = data_q[c];
        end
    end
endmodule
